// File: rtl/led_pwm_driver.sv
// -----------------------------------------------------------------------------
// led_pwm_driver
//
// Brightness-to-pulse stage of the LED dimming path. Duty requests arrive on a
// valid/ready handshake, wait in a one-deep shadow register, and are applied
// only when the PWM period wraps, so an output period is never cut short.
//
// Parameters
//   WIDTH     duty and period-counter width in bits
//   PRESCALE  sys_clk cycles per PWM tick (legal range >= 1)
//
// Ports
//   sys_clk       system clock, everything on the rising edge
//   rst           synchronous, active-high reset
//   din           requested duty level
//   din_valid     din is valid this cycle
//   din_ready     block can accept din this cycle (~pending & ~rst)
//   sout          registered PWM output, always equal to (cnt < duty_active)
//   period_start  one-cycle pulse in the first cycle of every new period
//                 (no pulse for the first period after reset)
//   duty_active   duty level currently being applied
// -----------------------------------------------------------------------------
module led_pwm_driver #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             period_start,
    output logic [WIDTH-1:0] duty_active
);

    // A one-state prescaler still needs a 1-bit register to keep widths legal;
    // it simply never leaves 0 and tick is then high every cycle.
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // The period counter stops one short of all-ones (MAX = 2^WIDTH - 1 ticks),
    // which is what lets an all-ones duty hold sout high for the whole period.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_cnt_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] shadow;
    logic             pending;
    logic [WIDTH-1:0] duty_next;
    logic             sout_next;
    logic             tick;
    logic             boundary;
    logic             accept;

    assign din_ready = ~pending & ~rst;
    assign accept    = din_valid & din_ready;

    // NOTE: every signal driven here gets a value before any condition is
    // evaluated, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        tick         = 1'b0;
        boundary     = 1'b0;
        pre_cnt_next = pre_cnt;
        cnt_next     = cnt;
        duty_next    = duty_active;
        sout_next    = 1'b0;

        tick     = (pre_cnt == PRE_LAST);
        boundary = tick && (cnt == CNT_LAST);

        if (tick) begin
            pre_cnt_next = '0;
        end else begin
            pre_cnt_next = pre_cnt + PRE_W'(1);
        end

        if (boundary) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = cnt + WIDTH'(1);
        end

        if (boundary && pending) begin
            duty_next = shadow;
        end

        // sout is registered from the next-state values so the flop always
        // agrees with the counter and duty that are live in the same cycle.
        sout_next = (cnt_next < duty_next);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order in this block.
    // All registers here are plain flops (no memory arrays), so every one of
    // them is cleared by reset, including the shadow data.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            duty_active  <= '0;
            sout         <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= pre_cnt_next;
            cnt          <= cnt_next;
            duty_active  <= duty_next;
            sout         <= sout_next;
            period_start <= boundary;

            // accept needs ~pending, so it can never collide with the transfer
            // below; an accept on a boundary with pending clear only fills the
            // shadow and waits for the following boundary.
            if (boundary && pending) begin
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= din;
                pending <= 1'b1;
            end
        end
    end

endmodule
